// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree, one register stage per level of 2:1 selection.
// Direct-select or auto-scan channel choice; select bits are consumed LSB first.
module mux_tree_pipe #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         in_valid,
    input  logic [SEL_W-1:0]             sel,
    input  logic [(2**SEL_W)*WIDTH-1:0]  din,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    output logic [SEL_W-1:0]             dout_ch
);

    localparam int N     = 2 ** SEL_W;
    localparam int NODES = N - 1;

    // All levels share one flat node array: level k starts at N - (N >> k) and holds N >> (k+1) words.
    function automatic int level_base(input int k);
        return N - (N >> k);
    endfunction

    logic [WIDTH-1:0] tree_q [NODES];
    logic [WIDTH-1:0] tree_d [NODES];
    logic [SEL_W-1:0] sel_q  [SEL_W];
    logic [SEL_W-1:0] sel_d  [SEL_W];
    logic [SEL_W-1:0] vld_q;
    logic [SEL_W-1:0] vld_d;
    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;
    logic [SEL_W-1:0] eff_sel;

    always_comb begin
        eff_sel = mode ? cnt_q : sel;
    end

    // The scan counter restarts at channel 0 whenever direct mode is selected.
    always_comb begin
        cnt_d = cnt_q;
        if (!mode) begin
            cnt_d = '0;
        end else if (in_valid) begin
            cnt_d = cnt_q + SEL_W'(1);
        end
    end

    always_comb begin
        tree_d = tree_q;
        sel_d  = sel_q;
        vld_d  = '0;
        vld_d[0] = in_valid;
        for (int k = 1; k < SEL_W; k++) begin
            vld_d[k] = vld_q[k-1];
        end

        if (in_valid) begin
            for (int j = 0; j < N / 2; j++) begin
                tree_d[j] = eff_sel[0] ? din[(2*j+1)*WIDTH +: WIDTH]
                                       : din[(2*j)*WIDTH +: WIDTH];
            end
            sel_d[0] = eff_sel;
        end

        // Each stage only advances data and select when a sample arrives from the stage before it.
        for (int k = 1; k < SEL_W; k++) begin
            if (vld_q[k-1]) begin
                for (int j = 0; j < (N >> (k + 1)); j++) begin
                    tree_d[level_base(k) + j] = sel_q[k-1][k]
                        ? tree_q[level_base(k-1) + 2*j + 1]
                        : tree_q[level_base(k-1) + 2*j];
                end
                sel_d[k] = sel_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                tree_q[i] <= '0;
            end
            for (int k = 0; k < SEL_W; k++) begin
                sel_q[k] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            tree_q <= tree_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout       = tree_q[NODES-1];
    assign dout_ch    = sel_q[SEL_W-1];
    assign dout_valid = vld_q[SEL_W-1];

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree (N = 2**SEL_W channels of WIDTH bits). It is built from one register stage per level of 2:1 selection. It supports a direct-select mode and an auto-scan mode in which an internal counter steps through the channels on every accepted sample. It sits between multi-channel sample sources and a single-channel consumer, and replaces fixed-size combinational mux trees where fan-in and timing require pipelining.

## Interface
- WIDTH, 8, data width per channel (>= 1)
- SEL_W, 2, select width / tree depth; N = 2**SEL_W channels (>= 1)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = direct select (use sel), 1 = auto-scan (use internal counter)
- in_valid  input  1  din and sel/counter are sampled this cycle
- sel  input  SEL_W  channel index in direct mode; ignored in scan mode
- din  input  N*WIDTH  flattened channels; channel i = din[i*WIDTH +: WIDTH]
- dout  output  WIDTH  selected channel data
- dout_valid  output  1  dout/dout_ch carry a new sample this cycle
- dout_ch  output  SEL_W  channel index that produced dout

## Operation
- Effective select: eff_sel = sel when mode=0, otherwise eff_sel = scan counter value.
- Level 0 (tree leaves):
  - On a clock edge with in_valid=1, it registers N/2 pairs.
  - Pair j = (eff_sel[0] ? ch[2j+1] : ch[2j]).
  - It captures eff_sel and valid alongside.
- Level k (1..SEL_W-1):
  - Registers pair j = (sel_k[k] ? prev[2j+1] : prev[2j]).
  - sel_k is the select carried with the sample.
- Select bits are consumed LSB first: bit 0 at the leaves, MSB at the output stage.
- Data and select registers of a stage load only when that stage's incoming valid is 1. Otherwise they hold.
- The valid bit of each stage always loads (bubbles propagate).
- Final stage drives dout, dout_ch (full eff_sel) and dout_valid.
- When dout_valid=0, dout and dout_ch hold their last valid values.
- Scan counter (SEL_W bits):
  - When mode=1 and in_valid=1, the sample uses the current count, then the count increments.
  - It wraps from N-1 to 0.
  - While mode=0 it is synchronously cleared to 0, so each scan period starts at channel 0.
  - When mode=1 and in_valid=0, it holds.
- Mode changes take effect on the next sampled input. In-flight samples complete with the select they were captured with.
- No backpressure: the consumer must accept one sample per cycle.

## Timing
- Latency: SEL_W cycles. A sample with in_valid=1 at edge n appears with dout_valid=1 after edge n+SEL_W-1, i.e. SEL_W register stages.
- SEL_W=1 degenerates to a single registered 2:1 mux with latency 1.
- Throughput: 1 sample per cycle. Back-to-back in_valid produces back-to-back dout_valid in the same order.
- Reset (asynchronous assert, synchronous-safe deassert):
  - All stage data, select and valid registers go to 0.
  - dout=0, dout_ch=0, dout_valid=0.
  - Scan counter goes to 0.
  - Reset mid-operation drops all in-flight samples. No dout_valid pulse may appear for them after release.
- First valid output after reset release requires in_valid plus SEL_W edges.
- Simultaneous in_valid=1 and mode change: the sample uses the mode value present at that edge.

## Test plan
- Direct select:
  - Setup: WIDTH=8, SEL_W=2, din={8'h44,8'h33,8'h22,8'h11}, mode=0.
  - Stimulus: sel=2 with in_valid for 1 cycle.
  - Required: exactly 2 edges later dout=8'h33, dout_ch=2, dout_valid=1 for one cycle, then dout holds 8'h33 with dout_valid=0.
- Back-to-back:
  - Stimulus: sel=0,1,2,3 on consecutive cycles with in_valid=1.
  - Required: dout=11,22,33,44 and dout_ch=0,1,2,3 on 4 consecutive cycles, no gaps.
- Auto-scan with bubbles:
  - Stimulus: mode=1, in_valid pattern 1,1,0,1,1,1.
  - Required: dout_ch sequence 0,1,2,3,0 with a single bubble in dout_valid matching the gap. Counter holds during the gap.
- Scan restart:
  - Stimulus: after 2 scanned samples, set mode=0 for 1 cycle, then mode=1.
  - Required: next scanned sample is channel 0.
- Reset mid-flight:
  - Stimulus: assert rst asynchronously between clock edges while 2 samples are in flight.
  - Required: dout=0, dout_ch=0, dout_valid=0 immediately. No dout_valid after release until new input.
- Parameter sweep:
  - Stimulus: SEL_W=1 and SEL_W=4 (16 channels, WIDTH=16) with random sel/din.
  - Required: each sample matches a reference model with latency SEL_W.
